// File: rtl/glycemic_pkg.sv
// Shared glycemic definitions: alarm encodings, index range and averaging
// window geometry, common to the calculator stage and the trend monitor.
package glycemic_pkg;

  localparam int unsigned IDX_W     = 4;  // glycemic index width (legal 0..8)
  localparam int unsigned SUM_W     = 6;  // window sum width (max 4*8 = 32)
  localparam int unsigned FILL_W    = 3;  // fill counter width (0..4)
  localparam int unsigned CNT_W     = 3;  // debounce counter width
  localparam int unsigned MAX_INDEX = 8;
  localparam int unsigned WIN_DEPTH = 4;

  typedef enum logic [1:0] {
    ALARM_NORMAL = 2'b00,
    ALARM_HYPER  = 2'b01,
    ALARM_HYPO   = 2'b10
  } alarm_e;

  // Clamp an out-of-range index to the legal maximum.
  function automatic logic [IDX_W-1:0] clampIndex(input logic [IDX_W-1:0] idx);
    return (idx > IDX_W'(MAX_INDEX)) ? IDX_W'(MAX_INDEX) : idx;
  endfunction

endpackage

// File: rtl/glycemic_window_avg.sv
// Four-sample sliding window with incremental running sum and floor average.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   sampleValid    - strobe: glycemicIndex valid this cycle
//   glycemicIndex  - raw index, values above 8 are clamped
//   avgIndex       - floor(sum/4), updated only once the window is full
//   avgStrobe      - one-cycle pulse per accepted sample with a full window
//   rangeError     - sticky: an out-of-range index was accepted
module glycemic_window_avg
  import glycemic_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             sampleValid,
  input  logic [IDX_W-1:0] glycemicIndex,
  output logic [IDX_W-1:0] avgIndex,
  output logic             avgStrobe,
  output logic             rangeError
);

  logic [WIN_DEPTH-1:0][IDX_W-1:0] win;     // win[0] is the oldest sample
  logic [SUM_W-1:0]                sum;
  logic [FILL_W-1:0]               fillCnt;

  logic [IDX_W-1:0]  clamped;
  logic [SUM_W-1:0]  sumNext;
  logic [FILL_W-1:0] fillNext;

  // Next-state values for the accepting edge.
  always_comb begin
    clamped  = clampIndex(glycemicIndex);
    sumNext  = sum + SUM_W'(clamped) - SUM_W'(win[0]);
    fillNext = (fillCnt == FILL_W'(WIN_DEPTH)) ? fillCnt : fillCnt + FILL_W'(1);
  end

  // Window, sum, fill and registered average.
  always_ff @(posedge clk) begin
    if (rst) begin
      win        <= '0;
      sum        <= '0;
      fillCnt    <= '0;
      avgIndex   <= '0;
      avgStrobe  <= 1'b0;
      rangeError <= 1'b0;
    end else begin
      avgStrobe <= 1'b0;
      if (sampleValid) begin
        win     <= {clamped, win[WIN_DEPTH-1:1]};
        sum     <= sumNext;
        fillCnt <= fillNext;
        if (glycemicIndex > IDX_W'(MAX_INDEX)) rangeError <= 1'b1;
        // Average is published only once four samples are in the window.
        if (fillNext == FILL_W'(WIN_DEPTH)) begin
          avgIndex  <= IDX_W'(sumNext >> 2);
          avgStrobe <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/glycemic_trend_monitor.sv
// Glycemic trend monitor: averages the index over four samples and raises a
// debounced HYPER/HYPO alarm with one step of exit hysteresis.
// Ports:
//   clk, rst       - clock, synchronous active-high reset
//   sampleValid    - strobe: glycemicIndex valid this cycle
//   glycemicIndex  - index from the calculator stage (0..8 legal)
//   avgIndex       - floor average of the last four samples
//   avgStrobe      - pulse when avgIndex updates with a full window
//   alarmLevel     - 00 NORMAL, 01 HYPER, 10 HYPO
//   rangeError     - sticky out-of-range input flag
module glycemic_trend_monitor
  import glycemic_pkg::*;
#(
  parameter int unsigned HIGH_TH  = 6,
  parameter int unsigned LOW_TH   = 2,
  parameter int unsigned DEBOUNCE = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sampleValid,
  input  logic [IDX_W-1:0] glycemicIndex,
  output logic [IDX_W-1:0] avgIndex,
  output logic             avgStrobe,
  output logic [1:0]       alarmLevel,
  output logic             rangeError
);

  localparam logic [IDX_W-1:0] HIGH_LIM   = IDX_W'(HIGH_TH);
  localparam logic [IDX_W-1:0] LOW_LIM    = IDX_W'(LOW_TH);
  localparam logic [IDX_W-1:0] HYPER_EXIT = IDX_W'(HIGH_TH - 1);
  localparam logic [IDX_W-1:0] HYPO_EXIT  = IDX_W'(LOW_TH + 1);
  localparam logic [CNT_W-1:0] DEB_LIM    = CNT_W'(DEBOUNCE);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  glycemic_window_avg uWindow (
    .clk           (clk),
    .rst           (rst),
    .sampleValid   (sampleValid),
    .glycemicIndex (glycemicIndex),
    .avgIndex      (avgIndex),
    .avgStrobe     (avgStrobe),
    .rangeError    (rangeError)
  );

  alarm_e            state, stateNext;
  logic [CNT_W-1:0]  hiCnt, hiNext, loCnt, loNext;
  logic [CNT_W-1:0]  hiInc, loInc;

  // State and debounce counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ALARM_NORMAL;
      hiCnt <= '0;
      loCnt <= '0;
    end else begin
      state <= stateNext;
      hiCnt <= hiNext;
      loCnt <= loNext;
    end
  end

  // Next-state: evaluated only on cycles carrying a fresh average.
  always_comb begin
    stateNext = state;
    hiNext    = hiCnt;
    loNext    = loCnt;
    hiInc     = (hiCnt == CNT_MAX) ? hiCnt : hiCnt + CNT_W'(1);
    loInc     = (loCnt == CNT_MAX) ? loCnt : loCnt + CNT_W'(1);
    if (avgStrobe) begin
      case (state)
        ALARM_NORMAL: begin
          if (avgIndex > HIGH_LIM) begin
            hiNext = hiInc;
            loNext = '0;
            if (hiInc >= DEB_LIM) begin
              stateNext = ALARM_HYPER;
              hiNext    = '0;
            end
          end else if (avgIndex < LOW_LIM) begin
            loNext = loInc;
            hiNext = '0;
            if (loInc >= DEB_LIM) begin
              stateNext = ALARM_HYPO;
              loNext    = '0;
            end
          end else begin
            hiNext = '0;
            loNext = '0;
          end
        end
        ALARM_HYPER: if (avgIndex <= HYPER_EXIT) stateNext = ALARM_NORMAL;
        ALARM_HYPO:  if (avgIndex >= HYPO_EXIT)  stateNext = ALARM_NORMAL;
        default:     stateNext = ALARM_NORMAL;
      endcase
    end
  end

  assign alarmLevel = state;

endmodule

// File: tb/tb_glycemic_trend_monitor.sv
// Directed self-checking bench for glycemic_trend_monitor.
module tb_glycemic_trend_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sampleValid = 1'b0;
  logic [3:0] glycemicIndex = 4'd0;
  logic [3:0] avgIndex;
  logic       avgStrobe;
  logic [1:0] alarmLevel;
  logic       rangeError;

  int checks = 0;
  int failures = 0;

  glycemic_trend_monitor #(.HIGH_TH(6), .LOW_TH(2), .DEBOUNCE(3)) dut (
    .clk           (clk),
    .rst           (rst),
    .sampleValid   (sampleValid),
    .glycemicIndex (glycemicIndex),
    .avgIndex      (avgIndex),
    .avgStrobe     (avgStrobe),
    .alarmLevel    (alarmLevel),
    .rangeError    (rangeError)
  );

  always #5 clk = ~clk;

  // One clock: inputs set on negedge, outputs observable #1 after posedge.
  task automatic drive(input logic v, input logic [3:0] val);
    @(negedge clk);
    sampleValid   = v;
    glycemicIndex = val;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset(input logic v, input logic [3:0] val);
    @(negedge clk);
    rst           = 1'b1;
    sampleValid   = v;
    glycemicIndex = val;
    @(posedge clk);
    #1;
  endtask

  task automatic releaseReset();
    @(negedge clk);
    rst         = 1'b0;
    sampleValid = 1'b0;
  endtask

  task automatic test_reset();
    pulseReset(1'b0, 4'd0);
    checks++; if (avgIndex !== 4'd0)   begin failures++; $display("FAIL reset_avg got=%0d exp=0", avgIndex); end
    checks++; if (avgStrobe !== 1'b0)  begin failures++; $display("FAIL reset_strobe got=%0b exp=0", avgStrobe); end
    checks++; if (alarmLevel !== 2'b00) begin failures++; $display("FAIL reset_alarm got=%0b exp=00", alarmLevel); end
    checks++; if (rangeError !== 1'b0) begin failures++; $display("FAIL reset_rangeErr got=%0b exp=0", rangeError); end
    releaseReset();
  endtask

  // Fill with 4,4,4,4: strobe only on the fourth, avg 4, no repeat when idle.
  task automatic test_fill();
    pulseReset(1'b0, 4'd0);
    releaseReset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd4);
      checks++; if (avgStrobe !== (i == 3)) begin failures++; $display("FAIL fill_strobe[%0d] got=%0b exp=%0b", i, avgStrobe, (i == 3)); end
      checks++; if (avgIndex !== ((i == 3) ? 4'd4 : 4'd0)) begin failures++; $display("FAIL fill_avg[%0d] got=%0d", i, avgIndex); end
    end
    drive(1'b0, 4'd0);
    checks++; if (avgStrobe !== 1'b0)  begin failures++; $display("FAIL fill_idle_strobe got=%0b exp=0", avgStrobe); end
    checks++; if (avgIndex !== 4'd4)   begin failures++; $display("FAIL fill_idle_avg got=%0d exp=4", avgIndex); end
    checks++; if (alarmLevel !== 2'b00) begin failures++; $display("FAIL fill_alarm got=%0b exp=00", alarmLevel); end
  endtask

  // Twelve 8s back-to-back -> HYPER, then hysteresis exit.
  task automatic test_hyper();
    logic [3:0] seq[7];
    logic [3:0] expAvg[7];
    logic [1:0] expAlarm[7];
    pulseReset(1'b0, 4'd0);
    releaseReset();
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 4'd8);
      checks++; if (avgStrobe !== (i >= 3)) begin failures++; $display("FAIL hyper_strobe[%0d] got=%0b", i, avgStrobe); end
      checks++; if (avgIndex !== ((i >= 3) ? 4'd8 : 4'd0)) begin failures++; $display("FAIL hyper_avg[%0d] got=%0d", i, avgIndex); end
      checks++; if (alarmLevel !== ((i >= 6) ? 2'b01 : 2'b00)) begin failures++; $display("FAIL hyper_alarm[%0d] got=%0b", i, alarmLevel); end
    end
    // 5 -> avg 7 (stay); refill to 8,8,8,8; then 0,0 -> avg 6 (stay), 4 (exit).
    seq      = '{4'd5, 4'd8, 4'd8, 4'd8, 4'd8, 4'd0, 4'd0};
    expAvg   = '{4'd7, 4'd7, 4'd7, 4'd7, 4'd8, 4'd6, 4'd4};
    expAlarm = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b01};
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, seq[i]);
      checks++; if (avgIndex !== expAvg[i]) begin failures++; $display("FAIL hyper_seq_avg[%0d] got=%0d exp=%0d", i, avgIndex, expAvg[i]); end
      checks++; if (alarmLevel !== expAlarm[i]) begin failures++; $display("FAIL hyper_seq_alarm[%0d] got=%0b exp=%0b", i, alarmLevel, expAlarm[i]); end
    end
    drive(1'b0, 4'd0);
    checks++; if (alarmLevel !== 2'b00) begin failures++; $display("FAIL hyper_exit got=%0b exp=00", alarmLevel); end
  endtask

  // Six 0s -> HYPO; 15 clamps to 8, sets sticky rangeError, avg 2 stays HYPO.
  task automatic test_hypo_range();
    pulseReset(1'b0, 4'd0);
    releaseReset();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 4'd0);
      checks++; if (alarmLevel !== 2'b00) begin failures++; $display("FAIL hypo_pre_alarm[%0d] got=%0b", i, alarmLevel); end
    end
    drive(1'b1, 4'd15);
    checks++; if (alarmLevel !== 2'b10) begin failures++; $display("FAIL hypo_alarm got=%0b exp=10", alarmLevel); end
    checks++; if (avgIndex !== 4'd2)    begin failures++; $display("FAIL hypo_clamp_avg got=%0d exp=2", avgIndex); end
    checks++; if (avgStrobe !== 1'b1)   begin failures++; $display("FAIL hypo_clamp_strobe got=%0b exp=1", avgStrobe); end
    checks++; if (rangeError !== 1'b1)  begin failures++; $display("FAIL range_set got=%0b exp=1", rangeError); end
    drive(1'b0, 4'd0);
    drive(1'b1, 4'd2);  // window 0,0,8,2 -> avg 2, still HYPO
    checks++; if (alarmLevel !== 2'b10) begin failures++; $display("FAIL hypo_hold got=%0b exp=10", alarmLevel); end
    checks++; if (avgIndex !== 4'd2)    begin failures++; $display("FAIL hypo_hold_avg got=%0d exp=2", avgIndex); end
    checks++; if (rangeError !== 1'b1)  begin failures++; $display("FAIL range_sticky got=%0b exp=1", rangeError); end
  endtask

  // Reset with a simultaneous sample while in HYPO: everything restarts.
  task automatic test_reset_mid_alarm();
    pulseReset(1'b1, 4'd8);
    checks++; if (alarmLevel !== 2'b00) begin failures++; $display("FAIL rst_mid_alarm got=%0b exp=00", alarmLevel); end
    checks++; if (avgIndex !== 4'd0)    begin failures++; $display("FAIL rst_mid_avg got=%0d exp=0", avgIndex); end
    checks++; if (avgStrobe !== 1'b0)   begin failures++; $display("FAIL rst_mid_strobe got=%0b exp=0", avgStrobe); end
    checks++; if (rangeError !== 1'b0)  begin failures++; $display("FAIL rst_mid_range got=%0b exp=0", rangeError); end
    releaseReset();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd8);
      checks++; if (avgStrobe !== (i == 3)) begin failures++; $display("FAIL rst_refill_strobe[%0d] got=%0b", i, avgStrobe); end
      checks++; if (avgIndex !== ((i == 3) ? 4'd8 : 4'd0)) begin failures++; $display("FAIL rst_refill_avg[%0d] got=%0d", i, avgIndex); end
    end
  endtask

  // Averages alternate 7,6,7,6,7,6: high count never reaches 2, stays NORMAL.
  task automatic test_alternate();
    logic [3:0] seq[9];
    logic [3:0] expAvg[9];
    pulseReset(1'b0, 4'd0);
    releaseReset();
    seq    = '{4'd8, 4'd6, 4'd8, 4'd6, 4'd7, 4'd7, 4'd7, 4'd7, 4'd6};
    expAvg = '{4'd0, 4'd0, 4'd0, 4'd7, 4'd6, 4'd7, 4'd6, 4'd7, 4'd6};
    for (int i = 0; i < 9; i++) begin
      drive(1'b1, seq[i]);
      checks++; if (avgIndex !== expAvg[i]) begin failures++; $display("FAIL alt_avg[%0d] got=%0d exp=%0d", i, avgIndex, expAvg[i]); end
      checks++; if (alarmLevel !== 2'b00)   begin failures++; $display("FAIL alt_alarm[%0d] got=%0b exp=00", i, alarmLevel); end
    end
    drive(1'b0, 4'd0);
    checks++; if (alarmLevel !== 2'b00) begin failures++; $display("FAIL alt_alarm_final got=%0b exp=00", alarmLevel); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_hyper();
    test_hypo_range();
    test_reset_mid_alarm();
    test_alternate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/glycemic_trend_monitor.md
GLYCEMIC_TREND_MONITOR -- requirements
Module: glycemic_trend_monitor

Interface
REQ-001 Parameter HIGH_TH, default 6, average strictly above this counts as a high reading.
REQ-002 Parameter LOW_TH, default 2, average strictly below this counts as a low reading.
REQ-003 Parameter DEBOUNCE, default 3, number of consecutive qualifying averages (1..7) needed to enter an alarm state.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 sampleValid  input  1  one-cycle strobe: glycemicIndex is valid this cycle.
REQ-007 glycemicIndex  input  4  popcount-based index from the calculator stage; legal range 0..8.
REQ-008 avgIndex  output  4  floor average of the last four accepted samples.
REQ-009 avgStrobe  output  1  one-cycle pulse when avgIndex is updated and the window is full.
REQ-010 alarmLevel  output  2  00 NORMAL, 01 HYPER (high), 10 HYPO (low); 11 never driven.
REQ-011 rangeError  output  1  sticky flag: an input above 8 was received.

Function
REQ-012 A sample is accepted on each rising edge with sampleValid=1; with sampleValid=0 no state changes except pending-output timing.
REQ-013 Accepted values 9..15 SHALL be clamped to 8 before entering the window, and SHALL set rangeError on the same edge.
REQ-014 The window is a 4-entry shift register; each accepted sample enters at the newest slot and the oldest is discarded.
REQ-015 The running sum is 6 bits wide and is updated incrementally (add new, subtract evicted); it never overflows because the maximum is 32.
REQ-016 A fill counter (0..4, saturating at 4) counts accepted samples since reset.
REQ-017 avgIndex = sum >> 2 (truncating), registered one cycle after the accepting edge; avgStrobe pulses in that same cycle, but only if the fill count is 4.
REQ-018 Before four samples have been accepted, avgIndex SHALL hold 0 and avgStrobe SHALL stay 0.
REQ-019 Back-to-back sampleValid on consecutive cycles is fully supported; each accepted sample produces exactly one avgStrobe once the window is full.
REQ-020 FSM states: NORMAL, HYPER, HYPO; it evaluates only in cycles with avgStrobe=1, and state and alarmLevel update on that edge.
REQ-021 In NORMAL: avg>HIGH_TH increments hiCnt and clears loCnt; avg<LOW_TH increments loCnt and clears hiCnt; otherwise both counters clear.
REQ-022 NORMAL->HYPER when hiCnt reaches DEBOUNCE, and NORMAL->HYPO when loCnt reaches DEBOUNCE; both counters clear on the transition.
REQ-023 HYPER->NORMAL on the first average <=HIGH_TH-1 (hysteresis of 1).
REQ-024 HYPO->NORMAL on the first average >=LOW_TH+1.
REQ-025 HYPER and HYPO never transition directly to each other; a direct swing passes through NORMAL first.
REQ-026 The alarm counters are 3 bits wide and saturate.

Reset
REQ-027 While rst=1 at an edge, the window, sum, fill counter, hiCnt and loCnt SHALL clear and the FSM SHALL go to NORMAL; avgIndex=0, avgStrobe=0, alarmLevel=00, rangeError=0.
REQ-028 rst SHALL take priority over a simultaneous sampleValid, and the sample is dropped.
REQ-029 A reset during an alarm state or a partial fill SHALL restart the fill from zero; no stale average is emitted afterwards.

Structure
REQ-030 The alarm encodings (NORMAL/HYPER/HYPO), the MAX_INDEX=8 constant and the window depth of 4 SHALL live in a shared glycemic package used by the calculator and this block.
REQ-031 The window, sum and average logic SHALL be one sub-module, glycemic_window_avg; the FSM stays in the top module.

Verification
REQ-032 Reset, then samples 4,4,4,4 on consecutive cycles -> no avgStrobe after the first three; a single avgStrobe with avgIndex=4 one cycle after the fourth; alarmLevel=00.
REQ-033 Reset, then 12 samples of value 8 -> the first avgStrobe shows avg 8; hiCnt reaches 3 on the third strobe and alarmLevel=01 from that edge; the next sample of 5 gives avg 7, so the state stays HYPER.
REQ-034 From HYPER with the window at 8,8,8,8, feed 0,0 -> avg 6 then 4; the exit threshold is <=5, so the state returns to NORMAL on the avg-4 strobe.
REQ-035 Reset, then samples 0 x6 -> HYPO on the third strobe; then a sample of 15 -> clamped to 8, rangeError=1 and stays set, avg=2 (stays HYPO).
REQ-036 Assert rst together with sampleValid mid-alarm -> all outputs 0/NORMAL on the next cycle; the next 3 samples produce no avgStrobe.
REQ-037 Alternate high/low averages (7,1,7,1) with DEBOUNCE=3 -> the counters clear each time and alarmLevel stays 00.
